vram_fetch_arbiter: RTL and testbench

- Shares one single-port synchronous 8-bit frame buffer RAM between the display refresh path and a pixel writer (drawing engine or CPU).
- Prefetches pixels in raster order into a show-ahead FIFO and drives PIXEL_DATA into the VGA timing/colour block, popping one pixel per DISPLAY_EN cycle.
- The writer gets every memory slot the display does not urgently need.
- Runs entirely in the VGACLK domain.

---
 rtl/vram_fetch_arbiter_if.sv | 30 +++
 rtl/vram_fetch_arbiter.sv | 122 ++++++++++++
 tb/tb_vram_fetch_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/vram_fetch_arbiter_if.sv
// rtl/vram_fetch_arbiter_if.sv - display, writer and frame buffer signals of the VRAM fetch arbiter
interface vram_fetch_arbiter_if #(
  parameter int AW = 20
);
  logic          FRAME_START;
  logic          DISPLAY_EN;
  logic [7:0]    PIXEL_DATA;
  logic          UNDERFLOW;
  logic          WR_VALID;
  logic          WR_READY;
  logic [AW-1:0] WR_ADDR;
  logic [7:0]    WR_DATA;
  logic          MEM_EN;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [7:0]    MEM_WDATA;
  logic [7:0]    MEM_RDATA;

  // Arbiter side.
  modport master (
    input  FRAME_START, DISPLAY_EN, WR_VALID, WR_ADDR, WR_DATA, MEM_RDATA,
    output PIXEL_DATA, UNDERFLOW, WR_READY, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA
  );

  // Timing block, writer and RAM side.
  modport slave (
    output FRAME_START, DISPLAY_EN, WR_VALID, WR_ADDR, WR_DATA, MEM_RDATA,
    input  PIXEL_DATA, UNDERFLOW, WR_READY, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA
  );
endinterface

// File: rtl/vram_fetch_arbiter.sv
// rtl/vram_fetch_arbiter.sv - frame buffer slot arbiter with raster prefetch FIFO for the display
module vram_fetch_arbiter #(
  parameter int H_PIX      = 1024,
  parameter int V_PIX      = 768,
  parameter int AW         = 20,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WM     = 8
) (
  input  logic                  VGACLK,
  input  logic                  RST_N_IN,
  vram_fetch_arbiter_if.master  bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [AW-1:0] LAST_ADDR  = AW'(H_PIX * V_PIX - 1);
  localparam logic [CW:0]   LOW_WM_L   = (CW+1)'(LOW_WM);
  localparam logic [CW:0]   DEPTH_L    = (CW+1)'(FIFO_DEPTH);

  logic [1:0]    state;
  logic [AW-1:0] fetch_addr;
  logic          rd_pending;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          underflow;
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic [CW:0]   level;
  logic          fetching;
  logic          urgent;
  logic          can_read;
  logic          rd_slot;
  logic          wr_slot;
  logic          push;
  logic          pop;

  // Slot arbitration: urgent display read, then writer, then opportunistic prefetch.
  always_comb begin
    level    = {1'b0, count} + (CW+1)'(rd_pending);
    fetching = (state == S_FETCH);
    urgent   = fetching && (level < LOW_WM_L);
    can_read = fetching && (level < DEPTH_L);
    rd_slot  = 1'b0;
    wr_slot  = 1'b0;
    if (bus.FRAME_START) begin
      // Restart cycle: no read, but a pending write is still served.
      wr_slot = bus.WR_VALID;
    end else if (urgent) begin
      rd_slot = 1'b1;
    end else if (bus.WR_VALID) begin
      wr_slot = 1'b1;
    end else if (can_read) begin
      rd_slot = 1'b1;
    end
  end

  // A returning read is only kept if no flush happened since it was issued.
  assign push = rd_pending && !bus.FRAME_START;
  assign pop  = bus.DISPLAY_EN && (count != '0);

  assign bus.WR_READY   = !(urgent && !bus.FRAME_START);
  assign bus.MEM_EN     = rd_slot || wr_slot;
  assign bus.MEM_WE     = wr_slot;
  assign bus.MEM_ADDR   = wr_slot ? bus.WR_ADDR : (rd_slot ? fetch_addr : '0);
  assign bus.MEM_WDATA  = bus.WR_DATA;
  assign bus.PIXEL_DATA = (count != '0) ? fifo_mem[rd_ptr] : 8'h00;
  assign bus.UNDERFLOW  = underflow;

  // Frame FSM, fetch address, FIFO pointers and sticky underflow flag.
  always_ff @(posedge VGACLK or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      state      <= S_IDLE;
      fetch_addr <= '0;
      rd_pending <= 1'b0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      underflow  <= 1'b0;
    end else begin
      if (bus.DISPLAY_EN && (count == '0)) begin
        underflow <= 1'b1;
      end
      if (bus.FRAME_START) begin
        state      <= S_FETCH;
        fetch_addr <= '0;
        rd_pending <= 1'b0;
        count      <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        rd_pending <= rd_slot;
        if (rd_slot) begin
          fetch_addr <= fetch_addr + 1'b1;
          if (fetch_addr == LAST_ADDR) begin
            state <= S_DONE;
          end
        end
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // FIFO storage needs no reset; count gates every read of it.
  always_ff @(posedge VGACLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.MEM_RDATA;
    end
  end

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// tb/tb_vram_fetch_arbiter.sv - randomized bench for vram_fetch_arbiter against a queue-based model
module tb_vram_fetch_arbiter;

  localparam int H    = 64;
  localparam int V    = 8;
  localparam int AW   = 10;
  localparam int D    = 16;
  localparam int LW   = 8;
  localparam int NPIX = H * V;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_fetch_arbiter_if #(.AW(AW)) bus ();

  vram_fetch_arbiter #(
    .H_PIX(H), .V_PIX(V), .AW(AW), .FIFO_DEPTH(D), .LOW_WM(LW)
  ) dut (
    .VGACLK(clk),
    .RST_N_IN(rst_n),
    .bus(bus)
  );

  // Single-port synchronous RAM, preloaded with addr[7:0] while reset is held.
  logic [7:0] ram [1<<AW];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < (1<<AW); i++) ram[i] <= i[7:0];
      bus.MEM_RDATA <= 8'h00;
    end else if (bus.MEM_EN && bus.MEM_WE) begin
      ram[bus.MEM_ADDR] <= bus.MEM_WDATA;
    end else if (bus.MEM_EN) begin
      bus.MEM_RDATA <= ram[bus.MEM_ADDR];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pixel queue plus the one read in flight.
  logic [7:0] q [$];
  bit         pend;
  logic [7:0] pend_val;
  int         faddr;
  int         mst;     // 0 waiting for frame, 1 fetching, 2 frame fully fetched
  bit         muf;
  int         nreads;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend  = 1'b0;
    faddr = 0;
    mst   = 0;
    muf   = 1'b0;
  endtask

  task automatic step(input bit fs, input bit de, input bit wv, input int wa, input int wd);
    int  lvl;
    bit  urg, rd, wr;
    logic [AW-1:0] wa_v;
    wa_v = wa[AW-1:0];
    bus.FRAME_START = fs;
    bus.DISPLAY_EN  = de;
    bus.WR_VALID    = wv;
    bus.WR_ADDR     = wa_v;
    bus.WR_DATA     = wd[7:0];
    @(negedge clk);
    lvl = q.size() + int'(pend);
    urg = !fs && (mst == 1) && (lvl < LW);
    rd  = !fs && (mst == 1) && (urg || (!wv && lvl < D));
    wr  = wv && !urg;
    chk("wr_ready", 32'(bus.WR_READY), 32'(!urg));
    chk("mem_en", 32'(bus.MEM_EN), 32'(rd || wr));
    chk("mem_we", 32'(bus.MEM_WE), 32'(wr));
    if (rd) chk("mem_addr_rd", 32'(bus.MEM_ADDR), 32'(faddr));
    if (wr) begin
      chk("mem_addr_wr", 32'(bus.MEM_ADDR), 32'(wa_v));
      chk("mem_wdata", 32'(bus.MEM_WDATA), 32'(wd[7:0]));
    end
    chk("pixel", 32'(bus.PIXEL_DATA), (q.size() > 0) ? 32'(q[0]) : 32'h0);
    chk("underflow", 32'(bus.UNDERFLOW), 32'(muf));
    if (de && q.size() == 0) muf = 1'b1;
    if (de && q.size() > 0) void'(q.pop_front());
    if (pend && !fs) q.push_back(pend_val);
    if (fs) begin
      q.delete();
      pend  = 1'b0;
      faddr = 0;
      mst   = 1;
    end else begin
      pend = rd;
      if (rd) begin
        nreads++;
        pend_val = ram[faddr];
        if (faddr == NPIX - 1) mst = 2;
        faddr++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done();
    int guard;
    guard = 0;
    while (mst != 2 && guard < 2000) begin
      step(0, ($urandom_range(0, 7) != 0), 1'b0, 0, 0);
      guard++;
    end
    chk("done_timeout", 32'(mst == 2), 32'h1);
  endtask

  initial begin
    bus.FRAME_START = 1'b0;
    bus.DISPLAY_EN  = 1'b0;
    bus.WR_VALID    = 1'b0;
    bus.WR_ADDR     = '0;
    bus.WR_DATA     = '0;
    model_reset();
    nreads = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pixel", 32'(bus.PIXEL_DATA), 32'h0);
    chk("rst_underflow", 32'(bus.UNDERFLOW), 32'h0);
    chk("rst_mem_en", 32'(bus.MEM_EN), 32'h0);
    chk("rst_mem_we", 32'(bus.MEM_WE), 32'h0);
    chk("rst_mem_addr", 32'(bus.MEM_ADDR), 32'h0);
    chk("rst_wr_ready", 32'(bus.WR_READY), 32'h1);
    rst_n = 1'b1;

    // Idle: only writes reach the RAM before the first frame start.
    for (int i = 0; i < 4; i++) step(0, 0, 1'b1, $urandom_range(600, 1023), $urandom);
    step(0, 0, 0, 0, 0);

    // Prefetch with display off: exactly FIFO_DEPTH reads, then quiet.
    nreads = 0;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 24; i++) step(0, 0, 0, 0, 0);
    chk("prefetch_reads", 32'(nreads), 32'(D));
    chk("prefetch_head", 32'(bus.PIXEL_DATA), 32'h0);

    // Active display, no writer.
    for (int i = 0; i < 300; i++) step(0, 1, 0, 0, 0);
    chk("display_no_underflow", 32'(bus.UNDERFLOW), 32'h0);

    // Writer held busy during an active line.
    for (int i = 0; i < 40; i++) step(0, 1, 1, $urandom_range(0, 1023), $urandom);
    // Mixed traffic with display gaps so the writer gets slots.
    for (int i = 0; i < 150; i++)
      step(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), $urandom_range(0, 1023), $urandom);
    chk("mixed_no_underflow", 32'(bus.UNDERFLOW), 32'h0);

    // Asynchronous reset in the middle of a cycle.
    bus.WR_VALID = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pixel", 32'(bus.PIXEL_DATA), 32'h0);
    chk("arst_mem_en", 32'(bus.MEM_EN), 32'h0);
    chk("arst_mem_addr", 32'(bus.MEM_ADDR), 32'h0);
    chk("arst_wr_ready", 32'(bus.WR_READY), 32'h1);
    chk("arst_underflow", 32'(bus.UNDERFLOW), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);

    // Whole frame, then writer-only operation.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
    run_to_done();
    for (int i = 0; i < 20; i++) step(0, 1, 1, $urandom_range(0, 1023), $urandom);

    // Display enabled one cycle after frame start: underflow is sticky.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("underflow_set", 32'(bus.UNDERFLOW), 32'h1);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
    chk("underflow_sticky", 32'(bus.UNDERFLOW), 32'h1);

    // Frame start with a read in flight: returning data must be dropped.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    chk("restart_head", 32'(bus.PIXEL_DATA), 32'(ram[0]));
    for (int i = 0; i < 30; i++) step(0, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
